// File: rtl/spi_target_pkg.sv
// Shared constants and types for the SPI target.
// Holds the byte width, FSM state encoding and synchroniser depth.
package spi_target_pkg;

    localparam int unsigned SpiByteW = 8;
    localparam int unsigned SyncStages = 2;

    typedef enum logic {
        StIdle,
        StActive
    } spi_state_e;

endpackage

// File: rtl/spi_target_rx_fifo.sv
// Synchronous RX FIFO for received SPI bytes.
// Ports: wvalid/wdata push, full; rvalid/rready/rdata pop; level occupancy.
module spi_target_rx_fifo
    import spi_target_pkg::*;
#(
    parameter int unsigned Depth = 8,
    localparam int unsigned AW = $clog2(Depth),
    localparam int unsigned PW = AW + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wvalid,
    input  logic [SpiByteW-1:0] wdata,
    output logic                full,
    output logic                rvalid,
    input  logic                rready,
    output logic [SpiByteW-1:0] rdata,
    output logic [PW-1:0]       level
);

    logic [SpiByteW-1:0] mem [Depth];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic          do_push;
    logic          do_pop;

    // Pointer MSBs differ only when the FIFO has wrapped a full lap.
    assign full = (wptr_q[AW] != rptr_q[AW]) &&
                  (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rvalid = (wptr_q != rptr_q);
    assign level = wptr_q - rptr_q;
    assign rdata = rvalid ? mem[rptr_q[AW-1:0]] : '0;

    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is still accepted.
    assign do_pop = rready && rvalid;
    assign do_push = wvalid && (!full || rready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target with oversampled pins, RX FIFO and TX byte handshake.
// Ports: spi_* pins, rx_* FIFO read side, tx_* byte input, overflow/abort flags.
module spi_target
    import spi_target_pkg::*;
#(
    parameter int unsigned RxFifoDepth = 8,
    parameter logic [SpiByteW-1:0] TxIdleByte = 8'hFF
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       spi_sck_i,
    input  logic                       spi_cs_ni,
    input  logic                       spi_copi_i,
    output logic                       spi_cipo_o,
    output logic                       spi_cipo_en_o,
    output logic [SpiByteW-1:0]        rx_data_o,
    output logic                       rx_valid_o,
    input  logic                       rx_ready_i,
    input  logic [SpiByteW-1:0]        tx_data_i,
    input  logic                       tx_valid_i,
    output logic                       tx_ready_o,
    output logic                       overflow_o,
    input  logic                       overflow_clr_i,
    output logic                       abort_o,
    output logic [$clog2(RxFifoDepth):0] rx_level_o
);

    logic [SyncStages-1:0] sck_ff;
    logic [SyncStages-1:0] cs_ff;
    logic [SyncStages-1:0] copi_ff;
    logic sck_sync;
    logic cs_sync;
    logic copi_sync;
    logic sck_q;
    logic cs_q;
    logic sck_rise;
    logic sck_fall;
    logic cs_rise;
    logic cs_fall;

    spi_state_e state_q;
    spi_state_e state_d;

    logic [2:0]          bit_cnt_q;
    logic [SpiByteW-1:0] tx_shift_q;
    logic [SpiByteW-2:0] rx_shift_q;
    logic [SpiByteW-1:0] rx_byte;

    logic tx_load;
    logic tx_shift_en;
    logic rx_en;
    logic frame_end;
    logic rx_push;
    logic fifo_full;

    // Pin synchronisers; reset values match an idle, deselected bus.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_ff <= '0;
            cs_ff <= '1;
            copi_ff <= '0;
            sck_q <= 1'b0;
            cs_q <= 1'b1;
        end else begin
            sck_ff <= {sck_ff[SyncStages-2:0], spi_sck_i};
            cs_ff <= {cs_ff[SyncStages-2:0], spi_cs_ni};
            copi_ff <= {copi_ff[SyncStages-2:0], spi_copi_i};
            sck_q <= sck_sync;
            cs_q <= cs_sync;
        end
    end

    assign sck_sync = sck_ff[SyncStages-1];
    assign cs_sync = cs_ff[SyncStages-1];
    assign copi_sync = copi_ff[SyncStages-1];

    assign sck_rise = sck_sync && !sck_q;
    assign sck_fall = !sck_sync && sck_q;
    assign cs_rise = cs_sync && !cs_q;
    assign cs_fall = !cs_sync && cs_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d = StActive;
                end
            end
            StActive: begin
                if (cs_rise) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A CS rise masks any SCK edge seen in the same cycle.
    always_comb begin
        tx_load = 1'b0;
        tx_shift_en = 1'b0;
        rx_en = 1'b0;
        frame_end = 1'b0;
        unique case (state_q)
            StIdle: begin
                tx_load = cs_fall;
            end
            StActive: begin
                if (cs_rise) begin
                    frame_end = 1'b1;
                end else if (sck_rise) begin
                    rx_en = 1'b1;
                end else if (sck_fall) begin
                    if (bit_cnt_q == 3'd0) begin
                        tx_load = 1'b1;
                    end else begin
                        tx_shift_en = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign rx_byte = {rx_shift_q, copi_sync};
    assign rx_push = rx_en && (bit_cnt_q == 3'd7);
    assign tx_ready_o = tx_load && tx_valid_i;
    assign abort_o = frame_end && (bit_cnt_q != 3'd0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_cnt_q <= '0;
            tx_shift_q <= TxIdleByte;
            rx_shift_q <= '0;
        end else begin
            if (tx_load) begin
                tx_shift_q <= tx_valid_i ? tx_data_i : TxIdleByte;
            end else if (tx_shift_en) begin
                tx_shift_q <= {tx_shift_q[SpiByteW-2:0], 1'b0};
            end else if (frame_end) begin
                tx_shift_q <= TxIdleByte;
            end

            if (frame_end || (state_q == StIdle && cs_fall)) begin
                bit_cnt_q <= '0;
                rx_shift_q <= '0;
            end else if (rx_en) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                rx_shift_q <= rx_byte[SpiByteW-2:0];
            end
        end
    end

    // Setting the flag beats a same-cycle clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_o <= 1'b0;
        end else if (rx_push && fifo_full && !rx_ready_i) begin
            overflow_o <= 1'b1;
        end else if (overflow_clr_i) begin
            overflow_o <= 1'b0;
        end
    end

    assign spi_cipo_o = tx_shift_q[SpiByteW-1];
    assign spi_cipo_en_o = !cs_sync;

    spi_target_rx_fifo #(
        .Depth(RxFifoDepth)
    ) u_rx_fifo (
        .clk(clk_i),
        .rst_n(rst_ni),
        .wvalid(rx_push),
        .wdata(rx_byte),
        .full(fifo_full),
        .rvalid(rx_valid_o),
        .rready(rx_ready_i),
        .rdata(rx_data_o),
        .level(rx_level_o)
    );

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target driving a mode-0 initiator at SCK = clk/8.
// Ports: none; instantiates spi_target with default parameters.
module tb_spi_target;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       sck = 1'b0;
    logic       cs_n = 1'b1;
    logic       copi = 1'b0;
    logic       cipo;
    logic       cipo_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       overflow;
    logic       overflow_clr = 1'b0;
    logic       abort;
    logic [3:0] rx_level;

    int errors = 0;
    int checks = 0;
    int txr_cnt = 0;
    int abort_cnt = 0;
    int txr0;
    int ab0;
    logic [7:0] miso;
    logic [7:0] miso2;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tx_ready) txr_cnt <= txr_cnt + 1;
        if (abort) abort_cnt <= abort_cnt + 1;
    end

    spi_target dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .spi_sck_i(sck),
        .spi_cs_ni(cs_n),
        .spi_copi_i(copi),
        .spi_cipo_o(cipo),
        .spi_cipo_en_o(cipo_en),
        .rx_data_o(rx_data),
        .rx_valid_o(rx_valid),
        .rx_ready_i(rx_ready),
        .tx_data_i(tx_data),
        .tx_valid_i(tx_valid),
        .tx_ready_o(tx_ready),
        .overflow_o(overflow),
        .overflow_clr_i(overflow_clr),
        .abort_o(abort),
        .rx_level_o(rx_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        #80;
    endtask

    task automatic cs_high();
        #40;
        cs_n = 1'b1;
        #80;
    endtask

    // Sends the top nbits of mosi MSB first; samples CIPO at each rise.
    task automatic xfer(input logic [7:0] mosi, input int nbits,
                        output logic [7:0] rd);
        rd = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            copi = mosi[7-i];
            #40;
            sck = 1'b1;
            rd[7-i] = cipo;
            #40;
            sck = 1'b0;
        end
    endtask

    task automatic pop();
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_cipo", cipo, 1);
        chk("rst_cipo_en", cipo_en, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_abort", abort, 0);
        chk("rst_level", rx_level, 0);
        rst_ni = 1'b1;
        #40;

        // Single byte with no TX data offered.
        txr0 = txr_cnt;
        ab0 = abort_cnt;
        cs_low();
        chk("single_cipo_en", cipo_en, 1);
        xfer(8'hA5, 8, miso);
        cs_high();
        chk("single_valid", rx_valid, 1);
        chk("single_data", rx_data, 8'hA5);
        chk("single_level", rx_level, 1);
        chk("single_abort", abort_cnt - ab0, 0);
        chk("notx_miso", miso, 8'hFF);
        chk("notx_tx_ready", txr_cnt - txr0, 0);
        chk("single_cipo_en_off", cipo_en, 0);
        pop();
        chk("single_drained", rx_level, 0);

        // Full-duplex two-byte frame.
        txr0 = txr_cnt;
        tx_data = 8'h3C;
        tx_valid = 1'b1;
        cs_low();
        tx_data = 8'hC3;
        xfer(8'h12, 8, miso);
        #40;
        tx_valid = 1'b0;
        xfer(8'h34, 8, miso2);
        cs_high();
        chk("duplex_miso0", miso, 8'h3C);
        chk("duplex_miso1", miso2, 8'hC3);
        chk("duplex_tx_ready", txr_cnt - txr0, 2);
        chk("duplex_level", rx_level, 2);
        chk("duplex_rx0", rx_data, 8'h12);
        pop();
        chk("duplex_rx1", rx_data, 8'h34);
        pop();

        // Overflow: nine bytes into an eight-entry FIFO.
        cs_low();
        for (int i = 0; i < 9; i++) begin
            xfer(8'h10 + 8'(i), 8, miso);
        end
        cs_high();
        chk("ovf_level", rx_level, 8);
        chk("ovf_flag", overflow, 1);
        for (int i = 0; i < 8; i++) begin
            chk("ovf_drain", rx_data, 8'h10 + 8'(i));
            pop();
        end
        chk("ovf_empty", rx_valid, 0);
        chk("ovf_sticky", overflow, 1);
        @(negedge clk);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // Abort after five bits, then a clean byte.
        ab0 = abort_cnt;
        cs_low();
        xfer(8'hFF, 5, miso);
        cs_high();
        chk("abort_pulse", abort_cnt - ab0, 1);
        chk("abort_level", rx_level, 0);
        cs_low();
        xfer(8'h5A, 8, miso);
        cs_high();
        chk("abort_next_level", rx_level, 1);
        chk("abort_next_data", rx_data, 8'h5A);
        chk("abort_once", abort_cnt - ab0, 1);

        // Asynchronous reset mid-byte, with a byte still in the FIFO.
        cs_low();
        xfer(8'hE0, 3, miso);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("arst_cipo", cipo, 1);
        chk("arst_cipo_en", cipo_en, 0);
        chk("arst_valid", rx_valid, 0);
        chk("arst_data", rx_data, 8'h00);
        chk("arst_level", rx_level, 0);
        chk("arst_abort", abort, 0);
        chk("arst_tx_ready", tx_ready, 0);
        cs_n = 1'b1;
        sck = 1'b0;
        #16;
        #40;
        rst_ni = 1'b1;
        #80;
        cs_low();
        xfer(8'h81, 8, miso);
        cs_high();
        chk("arst_next_level", rx_level, 1);
        chk("arst_next_data", rx_data, 8'h81);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI target (peripheral) that sits at the far end of the SPI link that sonata_system drives as initiator.
- Mode 0 only (CPOL=0, CPHA=0), MSB first, 8-bit frames.
- SCK, CS_N and COPI are oversampled into the single system clock domain. No clock is derived from SCK.
- Received bytes go into an RX FIFO read with a valid/ready handshake. Transmit bytes are taken from a valid/ready input and shifted out on CIPO.
- Used for board-to-board links and for loop-back testing of the SPI controller.

Parameters:
- RxFifoDepth, 8, RX FIFO entries; power of two, at least 2.
- TxIdleByte, 8'hFF, byte shifted out when no TX data is offered at a byte boundary.

Ports:
- clk_i  input  1  system clock; must run at 8x SCK or faster.
- rst_ni  input  1  asynchronous active-low reset.
- spi_sck_i  input  1  SPI clock from the initiator (asynchronous).
- spi_cs_ni  input  1  chip select, active low (asynchronous).
- spi_copi_i  input  1  controller-out / peripheral-in data.
- spi_cipo_o  output  1  peripheral-out / controller-in data.
- spi_cipo_en_o  output  1  CIPO output enable; high while CS is active.
- rx_data_o  output  8  head of the RX FIFO.
- rx_valid_o  output  1  RX FIFO not empty.
- rx_ready_i  input  1  pops the FIFO head when high together with rx_valid_o.
- tx_data_i  input  8  next byte to transmit.
- tx_valid_i  input  1  tx_data_i is valid.
- tx_ready_o  output  1  single-cycle pulse when tx_data_i is captured.
- overflow_o  output  1  sticky flag: an RX byte was dropped because the FIFO was full.
- overflow_clr_i  input  1  clears overflow_o.
- abort_o  output  1  single-cycle pulse when CS deasserts mid-byte.
- rx_level_o  output  $clog2(RxFifoDepth)+1  current RX FIFO occupancy.

Behaviour:
- **Reset (async, rst_ni low):**
  - Sync flops preset to SCK=0, CS_N=1, COPI=0.
  - State goes to IDLE, bit_cnt=0, tx_shift=TxIdleByte, FIFO empty.
  - Outputs: spi_cipo_o=1 (TxIdleByte MSB), spi_cipo_en_o=0, rx_valid_o=0, rx_data_o=0, tx_ready_o=0, overflow_o=0, abort_o=0, rx_level_o=0.
- **Synchronisation:**
  - SCK, CS_N and COPI each pass through a 2-flop synchroniser.
  - A further register on SCK and CS_N gives edge detection.
  - A pin edge is therefore acted on in the 3rd clk_i cycle after it.
  - COPI is sampled from its synchroniser output in the same cycle the SCK rise is detected.
- **State machine:**
  - IDLE:
    - Sync CS_N falling edge moves to ACTIVE.
    - On that edge: bit_cnt=0; if tx_valid_i, load tx_shift=tx_data_i and pulse tx_ready_o; otherwise load TxIdleByte.
  - ACTIVE, SCK rise:
    - rx_shift = {rx_shift[6:0], copi}; bit_cnt++.
    - When bit_cnt was 7, write {rx_shift[6:0], copi} to the FIFO in that cycle and wrap bit_cnt to 0.
  - ACTIVE, SCK fall:
    - If bit_cnt==0 (byte boundary), reload tx_shift from tx_data_i (pulse tx_ready_o) or from TxIdleByte.
    - Otherwise tx_shift <<= 1.
  - ACTIVE, CS_N rise: return to IDLE.
    - If bit_cnt!=0, discard the partial rx_shift and pulse abort_o.
    - tx_shift is reset to TxIdleByte.
  - CS_N rise in the same cycle as an SCK edge: the CS rise wins and the SCK edge is ignored.
- **CIPO:**
  - spi_cipo_o = tx_shift[7] at all times.
  - spi_cipo_en_o = ~cs_n_sync.
  - The first bit is valid at least 3 clk_i cycles after the CS pin falls. The initiator must leave at least half an SCK period before the first rise.
- **RX FIFO:**
  - rx_data_o shows the head, combinationally from storage.
  - A write and a pop in the same cycle are both honoured, even when the FIFO is full (the pop frees the slot).
  - A write while full with no pop drops the byte and sets overflow_o.
  - A byte is visible on rx_valid_o one cycle after the detected 8th SCK rise, i.e. 4 clk_i cycles after the pin edge.
- **overflow_o:** set has priority over overflow_clr_i in the same cycle.
- **Widths:** bit_cnt is 3 bits and wraps naturally. FIFO pointers are $clog2(RxFifoDepth)+1 bits, with the MSB used to distinguish full from empty.

Decomposition:
- Package spi_target_pkg holds:
  - SpiByteW=8.
  - typedef spi_state_e {StIdle, StActive}.
  - The sync stage count constant (2).
- One sub-module, spi_target_rx_fifo: synchronous FIFO parameterised by Depth, with wvalid/full/rvalid/rready/level.

Test Plan:
- Single byte: CS low, send 8'hA5 at SCK=clk/8, CS high -> rx_valid_o=1 with rx_data_o=8'hA5; rx_level_o=1; abort_o never pulses.
- Full-duplex: tx_valid_i held with tx_data_i=8'h3C, then 8'hC3, over a 2-byte frame with COPI 8'h12, 8'h34 -> initiator samples 8'h3C then 8'hC3; two tx_ready_o pulses; FIFO holds 8'h12, 8'h34.
- No TX data: tx_valid_i=0 for a 1-byte frame -> initiator reads 8'hFF; tx_ready_o stays 0.
- Overflow: send RxFifoDepth+1 bytes with rx_ready_i=0 -> rx_level_o=RxFifoDepth; overflow_o=1; after draining, bytes match the first RxFifoDepth sent. Then overflow_clr_i pulse -> overflow_o=0.
- Abort: CS rises after 5 SCK rises -> abort_o pulses once; FIFO level unchanged; the next full byte 8'h5A is received correctly.
- Async reset mid-byte: assert rst_ni low after 3 bits -> all outputs at their reset values immediately; the next clean frame of 8'h81 is received as 8'h81.
